// File: rtl/knownch_table.sv
// Candidate table of cluster-head adverts: refreshes repeat IDs, evicts the worst
// entry when full, and after an idle timeout scans for the best and backup CH.
module knownch_table #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_KCH,
  output logic                  kch_ready,
  input  logic                  HB_reset,
  input  logic [WORD_WIDTH-1:0] fCH_ID,
  input  logic [WORD_WIDTH-1:0] fCH_Hops,
  input  logic [WORD_WIDTH-1:0] fCH_QValue,
  output logic [WORD_WIDTH-1:0] chosenCH,
  output logic [WORD_WIDTH-1:0] hopsFromCH,
  output logic [WORD_WIDTH-1:0] chosenQ,
  output logic [WORD_WIDTH-1:0] backupCH,
  output logic                  ch_valid,
  output logic                  out_valid
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [WORD_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [TO_W-1:0]       TO_LOAD  = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPDATE,
    S_SCAN,
    S_OUT,
    S_CLEAR
  } state_t;

  // Fewer hops wins, then higher Q, then lower ID.
  function automatic logic better(
    input logic [WORD_WIDTH-1:0] a_hops,
    input logic [WORD_WIDTH-1:0] a_q,
    input logic [WORD_WIDTH-1:0] a_id,
    input logic [WORD_WIDTH-1:0] b_hops,
    input logic [WORD_WIDTH-1:0] b_q,
    input logic [WORD_WIDTH-1:0] b_id
  );
    if (a_hops != b_hops) return a_hops < b_hops;
    if (a_q != b_q) return a_q > b_q;
    return a_id < b_id;
  endfunction

  state_t state, state_nx;
  logic [TO_W-1:0]  timeout;
  logic [IDX_W-1:0] scan_idx;

  logic [DEPTH-1:0]      tbl_vld;
  logic [WORD_WIDTH-1:0] tbl_id   [DEPTH];
  logic [WORD_WIDTH-1:0] tbl_hops [DEPTH];
  logic [WORD_WIDTH-1:0] tbl_q    [DEPTH];

  logic [WORD_WIDTH-1:0] adv_id, adv_hops, adv_q;

  logic                  best_vld, sec_vld;
  logic [WORD_WIDTH-1:0] best_id, best_hops, best_q;
  logic [WORD_WIDTH-1:0] sec_id, sec_hops, sec_q;
  logic                  best_vld_nx, sec_vld_nx;
  logic [WORD_WIDTH-1:0] best_id_nx, best_hops_nx, best_q_nx;
  logic [WORD_WIDTH-1:0] sec_id_nx, sec_hops_nx, sec_q_nx;

  logic do_accept, do_dec, do_scan_start, do_scan_step, do_publish;
  logic do_update, do_reload, do_clear;

  logic             match_hit, free_hit, wr_en;
  logic [IDX_W-1:0] match_idx, free_idx, worst_idx, wr_idx;

  assign kch_ready = (state == S_IDLE) && !HB_reset;

  always_comb begin
    state_nx      = state;
    do_accept     = 1'b0;
    do_dec        = 1'b0;
    do_scan_start = 1'b0;
    do_scan_step  = 1'b0;
    do_publish    = 1'b0;
    do_update     = 1'b0;
    do_reload     = 1'b0;
    do_clear      = (state == S_CLEAR);
    if (HB_reset) begin
      state_nx = S_CLEAR;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_KCH) begin
            do_accept = 1'b1;
            state_nx  = S_UPDATE;
          end else if (timeout == '0) begin
            do_scan_start = 1'b1;
            state_nx      = S_SCAN;
          end else begin
            do_dec = 1'b1;
          end
        end
        S_UPDATE: begin
          do_update = 1'b1;
          state_nx  = S_IDLE;
        end
        S_SCAN: begin
          do_scan_step = 1'b1;
          if (scan_idx == LAST_IDX) begin
            do_publish = 1'b1;
            state_nx   = S_OUT;
          end
        end
        S_OUT: begin
          do_reload = 1'b1;
          state_nx  = S_IDLE;
        end
        S_CLEAR: begin
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
    if (do_clear) do_reload = 1'b1;
  end

  // Slot selection for the latched advert: refresh, free slot, or evict worst.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    worst_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tbl_vld[i] && (tbl_id[i] == adv_id)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!tbl_vld[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (better(tbl_hops[worst_idx], tbl_q[worst_idx], tbl_id[worst_idx],
                 tbl_hops[i], tbl_q[i], tbl_id[i]))
        worst_idx = IDX_W'(i);
    end
    wr_en  = 1'b0;
    wr_idx = '0;
    if (match_hit) begin
      wr_en  = 1'b1;
      wr_idx = match_idx;
    end else if (free_hit) begin
      wr_en  = 1'b1;
      wr_idx = free_idx;
    end else if (better(adv_hops, adv_q, adv_id,
                        tbl_hops[worst_idx], tbl_q[worst_idx], tbl_id[worst_idx])) begin
      wr_en  = 1'b1;
      wr_idx = worst_idx;
    end
  end

  // Best/second tracker update for the entry under the scan pointer.
  always_comb begin
    best_vld_nx  = best_vld;
    best_id_nx   = best_id;
    best_hops_nx = best_hops;
    best_q_nx    = best_q;
    sec_vld_nx   = sec_vld;
    sec_id_nx    = sec_id;
    sec_hops_nx  = sec_hops;
    sec_q_nx     = sec_q;
    if (tbl_vld[scan_idx]) begin
      if (!best_vld || better(tbl_hops[scan_idx], tbl_q[scan_idx], tbl_id[scan_idx],
                              best_hops, best_q, best_id)) begin
        sec_vld_nx   = best_vld;
        sec_id_nx    = best_id;
        sec_hops_nx  = best_hops;
        sec_q_nx     = best_q;
        best_vld_nx  = 1'b1;
        best_id_nx   = tbl_id[scan_idx];
        best_hops_nx = tbl_hops[scan_idx];
        best_q_nx    = tbl_q[scan_idx];
      end else if (!sec_vld || better(tbl_hops[scan_idx], tbl_q[scan_idx], tbl_id[scan_idx],
                                      sec_hops, sec_q, sec_id)) begin
        sec_vld_nx  = 1'b1;
        sec_id_nx   = tbl_id[scan_idx];
        sec_hops_nx = tbl_hops[scan_idx];
        sec_q_nx    = tbl_q[scan_idx];
      end
    end
  end

  // Control and published outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      timeout    <= TO_LOAD;
      scan_idx   <= '0;
      tbl_vld    <= '0;
      best_vld   <= 1'b0;
      sec_vld    <= 1'b0;
      chosenCH   <= ALL_ONES;
      hopsFromCH <= ALL_ONES;
      chosenQ    <= '0;
      backupCH   <= ALL_ONES;
      ch_valid   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      if (do_accept || do_reload) timeout <= TO_LOAD;
      else if (do_dec)            timeout <= timeout - TO_W'(1);
      if (do_scan_start) begin
        scan_idx <= '0;
        best_vld <= 1'b0;
        sec_vld  <= 1'b0;
      end
      if (do_scan_step) begin
        scan_idx <= scan_idx + IDX_W'(1);
        best_vld <= best_vld_nx;
        sec_vld  <= sec_vld_nx;
      end
      if (do_update && wr_en) tbl_vld[wr_idx] <= 1'b1;
      if (do_publish) begin
        chosenCH   <= best_vld_nx ? best_id_nx : ALL_ONES;
        hopsFromCH <= best_vld_nx ? best_hops_nx : ALL_ONES;
        chosenQ    <= best_vld_nx ? best_q_nx : '0;
        backupCH   <= sec_vld_nx ? sec_id_nx : ALL_ONES;
        ch_valid   <= best_vld_nx;
        out_valid  <= 1'b1;
      end
      if (do_clear) begin
        tbl_vld    <= '0;
        chosenCH   <= ALL_ONES;
        hopsFromCH <= ALL_ONES;
        chosenQ    <= '0;
        backupCH   <= ALL_ONES;
        ch_valid   <= 1'b0;
      end
    end
  end

  // Datapath storage; meaning is carried by the valid bits above.
  always_ff @(posedge clk) begin
    if (do_accept) begin
      adv_id   <= fCH_ID;
      adv_hops <= fCH_Hops;
      adv_q    <= fCH_QValue;
    end
    if (do_update && wr_en) begin
      tbl_id[wr_idx]   <= adv_id;
      tbl_hops[wr_idx] <= adv_hops;
      tbl_q[wr_idx]    <= adv_q;
    end
    if (do_scan_step) begin
      best_id   <= best_id_nx;
      best_hops <= best_hops_nx;
      best_q    <= best_q_nx;
      sec_id    <= sec_id_nx;
      sec_hops  <= sec_hops_nx;
      sec_q     <= sec_q_nx;
    end
  end

endmodule

// File: tb/tb_knownch_table.sv
// Directed bench for knownch_table at DEPTH=4, TIMEOUT=10.
module tb_knownch_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_KCH = 1'b0;
  logic        kch_ready;
  logic        HB_reset = 1'b0;
  logic [15:0] fCH_ID = '0, fCH_Hops = '0, fCH_QValue = '0;
  logic [15:0] chosenCH, hopsFromCH, chosenQ, backupCH;
  logic        ch_valid, out_valid;

  int checks = 0;
  int errors = 0;

  knownch_table #(.WORD_WIDTH(16), .DEPTH(4), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .en_KCH(en_KCH), .kch_ready(kch_ready), .HB_reset(HB_reset),
    .fCH_ID(fCH_ID), .fCH_Hops(fCH_Hops), .fCH_QValue(fCH_QValue),
    .chosenCH(chosenCH), .hopsFromCH(hopsFromCH), .chosenQ(chosenQ), .backupCH(backupCH),
    .ch_valid(ch_valid), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1; en_KCH = 1'b0; HB_reset = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_advert(input logic [15:0] id, input logic [15:0] h, input logic [15:0] q);
    bit ok;
    ok = 1'b0;
    en_KCH = 1'b1; fCH_ID = id; fCH_Hops = h; fCH_QValue = q;
    for (int n = 0; n < 60; n++) begin
      if (kch_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    en_KCH = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL advert_accept: id %0d not accepted within 60 cycles", id);
    end
  endtask

  // Returns the number of edges until out_valid is seen, or -1 if it never is.
  task automatic wait_out(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (chosenCH !== 16'hFFFF) begin errors++; $display("FAIL reset_chosen: got %h want ffff", chosenCH); end
    checks++; if (backupCH !== 16'hFFFF) begin errors++; $display("FAIL reset_backup: got %h want ffff", backupCH); end
    checks++; if (hopsFromCH !== 16'hFFFF) begin errors++; $display("FAIL reset_hops: got %h want ffff", hopsFromCH); end
    checks++; if (chosenQ !== 16'h0000) begin errors++; $display("FAIL reset_q: got %h want 0000", chosenQ); end
    checks++; if (ch_valid !== 1'b0) begin errors++; $display("FAIL reset_ch_valid: got %b want 0", ch_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (kch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", kch_ready); end
    rst = 1'b0;
  endtask

  task automatic test_empty_scan();
    int cyc;
    wait_out(cyc);
    checks++; if (cyc != 15) begin errors++; $display("FAIL empty_latency: got %0d want 15", cyc); end
    checks++; if (ch_valid !== 1'b0) begin errors++; $display("FAIL empty_ch_valid: got %b want 0", ch_valid); end
    checks++; if (chosenCH !== 16'hFFFF) begin errors++; $display("FAIL empty_chosen: got %h want ffff", chosenCH); end
    checks++; if (backupCH !== 16'hFFFF) begin errors++; $display("FAIL empty_backup: got %h want ffff", backupCH); end
    checks++; if (hopsFromCH !== 16'hFFFF) begin errors++; $display("FAIL empty_hops: got %h want ffff", hopsFromCH); end
    checks++; if (chosenQ !== 16'h0000) begin errors++; $display("FAIL empty_q: got %h want 0000", chosenQ); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_pulse_width: got %b want 0", out_valid); end
  endtask

  task automatic test_rank();
    int cyc;
    apply_reset();
    send_advert(16'd5, 16'd2, 16'd30);
    send_advert(16'd3, 16'd1, 16'd10);
    send_advert(16'd7, 16'd1, 16'd40);
    wait_out(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL rank_latency: got %0d want 16", cyc); end
    checks++; if (chosenCH !== 16'd7) begin errors++; $display("FAIL rank_chosen: got %0d want 7", chosenCH); end
    checks++; if (hopsFromCH !== 16'd1) begin errors++; $display("FAIL rank_hops: got %0d want 1", hopsFromCH); end
    checks++; if (chosenQ !== 16'd40) begin errors++; $display("FAIL rank_q: got %0d want 40", chosenQ); end
    checks++; if (backupCH !== 16'd3) begin errors++; $display("FAIL rank_backup: got %0d want 3", backupCH); end
    checks++; if (ch_valid !== 1'b1) begin errors++; $display("FAIL rank_ch_valid: got %b want 1", ch_valid); end
  endtask

  task automatic test_tiebreak();
    int cyc;
    apply_reset();
    send_advert(16'd9, 16'd1, 16'd40);
    send_advert(16'd4, 16'd1, 16'd40);
    wait_out(cyc);
    checks++; if (chosenCH !== 16'd4) begin errors++; $display("FAIL tie_chosen: got %0d want 4", chosenCH); end
    checks++; if (backupCH !== 16'd9) begin errors++; $display("FAIL tie_backup: got %0d want 9", backupCH); end
    send_advert(16'd4, 16'd3, 16'd40);
    wait_out(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL refresh_latency: got %0d want 16", cyc); end
    checks++; if (chosenCH !== 16'd9) begin errors++; $display("FAIL refresh_chosen: got %0d want 9", chosenCH); end
    checks++; if (backupCH !== 16'd4) begin errors++; $display("FAIL refresh_backup: got %0d want 4", backupCH); end
    checks++; if (hopsFromCH !== 16'd1) begin errors++; $display("FAIL refresh_hops: got %0d want 1", hopsFromCH); end
  endtask

  task automatic test_evict();
    int cyc;
    apply_reset();
    for (int i = 1; i <= 4; i++) send_advert(16'(i), 16'(i), 16'd0);
    wait_out(cyc);
    checks++; if (chosenCH !== 16'd1) begin errors++; $display("FAIL full_chosen: got %0d want 1", chosenCH); end
    checks++; if (backupCH !== 16'd2) begin errors++; $display("FAIL full_backup: got %0d want 2", backupCH); end
    send_advert(16'd8, 16'd2, 16'd0);
    send_advert(16'd9, 16'd5, 16'd99);
    // Push IDs 1 and 2 to the back so the rest of the table becomes visible.
    send_advert(16'd1, 16'd9, 16'd0);
    send_advert(16'd2, 16'd9, 16'd0);
    wait_out(cyc);
    checks++; if (chosenCH !== 16'd8) begin errors++; $display("FAIL evict_chosen: got %0d want 8", chosenCH); end
    checks++; if (hopsFromCH !== 16'd2) begin errors++; $display("FAIL evict_hops: got %0d want 2", hopsFromCH); end
    checks++; if (backupCH !== 16'd3) begin errors++; $display("FAIL evict_backup: got %0d want 3", backupCH); end
    checks++; if (ch_valid !== 1'b1) begin errors++; $display("FAIL evict_ch_valid: got %b want 1", ch_valid); end
  endtask

  task automatic test_back_to_back();
    int cyc, idle_n, wait_n;
    bit seen;
    logic [15:0] cap;
    apply_reset();
    send_advert(16'd5, 16'd2, 16'd30);
    @(posedge clk); #1;
    idle_n = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      idle_n++;
      if (!kch_ready) break;
    end
    checks++; if (idle_n != 11) begin errors++; $display("FAIL bp_scan_start: got %0d want 11", idle_n); end
    en_KCH = 1'b1; fCH_ID = 16'd6; fCH_Hops = 16'd1; fCH_QValue = 16'd5;
    wait_n = 0; seen = 1'b0; cap = '0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      wait_n++;
      if (out_valid) begin seen = 1'b1; cap = chosenCH; end
      if (kch_ready) break;
    end
    checks++; if (wait_n != 5) begin errors++; $display("FAIL bp_ready_delay: got %0d want 5", wait_n); end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_out_seen: got %b want 1", seen); end
    checks++; if (cap !== 16'd5) begin errors++; $display("FAIL bp_out_chosen: got %0d want 5", cap); end
    @(posedge clk); #1;
    en_KCH = 1'b0;
    checks++; if (kch_ready !== 1'b0) begin errors++; $display("FAIL bp_update_ready: got %b want 0", kch_ready); end
    wait_out(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL bp_timeout_restart: got %0d want 16", cyc); end
    checks++; if (chosenCH !== 16'd6) begin errors++; $display("FAIL bp_chosen: got %0d want 6", chosenCH); end
    checks++; if (backupCH !== 16'd5) begin errors++; $display("FAIL bp_backup: got %0d want 5", backupCH); end
  endtask

  task automatic test_hb_reset();
    int cyc, n_wait;
    apply_reset();
    send_advert(16'd3, 16'd1, 16'd10);
    send_advert(16'd7, 16'd2, 16'd5);
    wait_out(cyc);
    checks++; if (chosenCH !== 16'd3 || backupCH !== 16'd7) begin
      errors++; $display("FAIL hb_pre_outputs: got %0d/%0d want 3/7", chosenCH, backupCH);
    end
    @(posedge clk); #1;
    n_wait = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      n_wait++;
      if (!kch_ready) break;
    end
    checks++; if (n_wait != 11) begin errors++; $display("FAIL hb_scan_start: got %0d want 11", n_wait); end
    @(posedge clk); #1;
    HB_reset = 1'b1;
    @(posedge clk); #1;
    HB_reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hb_clear_out_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hb_idle_out_valid: got %b want 0", out_valid); end
    checks++; if (chosenCH !== 16'hFFFF) begin errors++; $display("FAIL hb_chosen: got %h want ffff", chosenCH); end
    checks++; if (backupCH !== 16'hFFFF) begin errors++; $display("FAIL hb_backup: got %h want ffff", backupCH); end
    checks++; if (hopsFromCH !== 16'hFFFF) begin errors++; $display("FAIL hb_hops: got %h want ffff", hopsFromCH); end
    checks++; if (chosenQ !== 16'h0000) begin errors++; $display("FAIL hb_q: got %h want 0000", chosenQ); end
    checks++; if (ch_valid !== 1'b0) begin errors++; $display("FAIL hb_ch_valid: got %b want 0", ch_valid); end
    wait_out(cyc);
    checks++; if (cyc != 15) begin errors++; $display("FAIL hb_next_latency: got %0d want 15", cyc); end
    checks++; if (ch_valid !== 1'b0 || chosenCH !== 16'hFFFF) begin
      errors++; $display("FAIL hb_next_empty: got valid %b id %h want 0 ffff", ch_valid, chosenCH);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    apply_reset();
    send_advert(16'd2, 16'd1, 16'd1);
    wait_out(cyc);
    checks++; if (chosenCH !== 16'd2) begin errors++; $display("FAIL ar_pre_chosen: got %0d want 2", chosenCH); end
    send_advert(16'd5, 16'd1, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (chosenCH !== 16'hFFFF) begin errors++; $display("FAIL ar_chosen: got %h want ffff", chosenCH); end
    checks++; if (hopsFromCH !== 16'hFFFF) begin errors++; $display("FAIL ar_hops: got %h want ffff", hopsFromCH); end
    checks++; if (chosenQ !== 16'h0000) begin errors++; $display("FAIL ar_q: got %h want 0000", chosenQ); end
    checks++; if (ch_valid !== 1'b0) begin errors++; $display("FAIL ar_ch_valid: got %b want 0", ch_valid); end
    checks++; if (kch_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b want 1", kch_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_out(cyc);
    checks++; if (cyc != 15) begin errors++; $display("FAIL ar_next_latency: got %0d want 15", cyc); end
    checks++; if (ch_valid !== 1'b0) begin errors++; $display("FAIL ar_next_empty: got %b want 0", ch_valid); end
  endtask

  initial begin
    test_reset();
    test_empty_scan();
    test_rank();
    test_tiebreak();
    test_evict();
    test_back_to_back();
    test_hb_reset();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
